// File: rtl/election_house_array_if.sv
// Per-house vote handshake: vote requests in, acknowledge pulses and cooldown status out.
interface election_house_array_if #(
  parameter int NUM_HOUSES = 4
);
  logic [NUM_HOUSES-1:0] vote;
  logic [NUM_HOUSES-1:0] voteAccepted;
  logic [NUM_HOUSES-1:0] coolingDown;

  modport master (output vote, input voteAccepted, input coolingDown);
  modport slave  (input vote, output voteAccepted, output coolingDown);
endinterface

// File: rtl/election_house_array.sv
// Election-house tile renderer with per-house vote cooldown and end-of-cooldown blink.
// Drawing outputs are one cycle behind pixelX/pixelY; the lowest-index house wins overlaps.
module election_house_array #(
  parameter int                      NUM_HOUSES      = 4,
  parameter int                      TILE_SIZE       = 32,
  parameter logic [8*NUM_HOUSES-1:0] HOUSE_IDX_X     = 32'h090F0309,
  parameter logic [8*NUM_HOUSES-1:0] HOUSE_IDX_Y     = 32'h01070707,
  parameter int                      COOLDOWN_FRAMES = 120,
  parameter int                      WARN_FRAMES     = 30,
  parameter int                      BLINK_PERIOD    = 8,
  parameter int                      CORNER          = 5,
  parameter int                      CENTER_LO       = 10,
  parameter int                      CENTER_HI       = 20,
  parameter logic [7:0]              COLOR_BODY      = 8'hF0,
  parameter logic [7:0]              COLOR_ACCENT    = 8'h00
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic [10:0]                  pixelX,
  input  logic [10:0]                  pixelY,
  input  logic [10:0]                  matrixTopLeftX,
  input  logic [10:0]                  matrixTopLeftY,
  input  logic                         startOfFrame,
  election_house_array_if.slave        vote_bus,
  output logic                         drawingRequest,
  output logic [2:0]                   houseIndex,
  output logic [10:0]                  offsetX,
  output logic [10:0]                  offsetY,
  output logic [7:0]                   RGBout
);

  localparam int CNT_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam int BLK_W = $clog2(BLINK_PERIOD + 1);

  localparam logic [12:0] TILE13  = 13'(TILE_SIZE);
  localparam logic [13:0] TILE14  = 14'(TILE_SIZE);
  localparam logic [10:0] C_LO    = 11'(CENTER_LO);
  localparam logic [10:0] C_HI    = 11'(CENTER_HI);
  localparam logic [10:0] CRN_LO  = 11'(CORNER);
  localparam logic [10:0] CRN_HI  = 11'(TILE_SIZE - CORNER);

  typedef enum logic {READY, COOLDOWN} state_t;

  state_t                 state     [NUM_HOUSES];
  logic [CNT_W-1:0]       cnt       [NUM_HOUSES];
  logic [BLK_W-1:0]       blink_cnt [NUM_HOUSES];
  logic [NUM_HOUSES-1:0]  blink_phase;

  function automatic logic in_band(input logic [10:0] o);
    return (o < CRN_LO) || (o >= CRN_HI);
  endfunction

  function automatic logic is_accent(input logic [10:0] ox, input logic [10:0] oy);
    logic center;
    center = (ox > C_LO) && (ox < C_HI) && (oy > C_LO) && (oy < C_HI);
    return center || (in_band(ox) && in_band(oy));
  endfunction

  // Cooldown FSMs: blink frames are counted once the decremented count is inside the warning window
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_HOUSES; i++) begin
        state[i]     <= READY;
        cnt[i]       <= '0;
        blink_cnt[i] <= '0;
      end
      blink_phase           <= '0;
      vote_bus.voteAccepted <= '0;
      vote_bus.coolingDown  <= '0;
    end else begin
      for (int i = 0; i < NUM_HOUSES; i++) begin
        vote_bus.voteAccepted[i] <= 1'b0;
        case (state[i])
          READY: begin
            if (vote_bus.vote[i]) begin
              state[i]                 <= COOLDOWN;
              cnt[i]                   <= CNT_W'(COOLDOWN_FRAMES);
              blink_cnt[i]             <= '0;
              blink_phase[i]           <= 1'b0;
              vote_bus.voteAccepted[i] <= 1'b1;
              vote_bus.coolingDown[i]  <= 1'b1;
            end
          end
          COOLDOWN: begin
            if (startOfFrame) begin
              if (cnt[i] == CNT_W'(1)) begin
                state[i]                <= READY;
                cnt[i]                  <= '0;
                blink_cnt[i]            <= '0;
                blink_phase[i]          <= 1'b0;
                vote_bus.coolingDown[i] <= 1'b0;
              end else begin
                cnt[i] <= cnt[i] - CNT_W'(1);
                if ((int'(cnt[i]) - 1) <= WARN_FRAMES) begin
                  if (blink_cnt[i] == BLK_W'(BLINK_PERIOD - 1)) begin
                    blink_cnt[i]   <= '0;
                    blink_phase[i] <= ~blink_phase[i];
                  end else begin
                    blink_cnt[i] <= blink_cnt[i] + BLK_W'(1);
                  end
                end
              end
            end
          end
          default: state[i] <= READY;
        endcase
      end
    end
  end

  // Stage p0: hit test and pattern lookup on the current pixel
  logic [12:0] px13, py13, tl_x, tl_y;
  logic        hit_p0, accent_sel_p0;
  logic [2:0]  idx_p0;
  logic [10:0] ox_p0, oy_p0;

  assign px13 = 13'(pixelX);
  assign py13 = 13'(pixelY);

  always_comb begin
    hit_p0        = 1'b0;
    idx_p0        = '0;
    ox_p0         = '0;
    oy_p0         = '0;
    accent_sel_p0 = 1'b0;
    tl_x          = '0;
    tl_y          = '0;
    // Descending scan so the lowest covering index is the last one written
    for (int i = NUM_HOUSES - 1; i >= 0; i--) begin
      tl_x = 13'(HOUSE_IDX_X[8*i +: 8]) * TILE13 + 13'(matrixTopLeftX);
      tl_y = 13'(HOUSE_IDX_Y[8*i +: 8]) * TILE13 + 13'(matrixTopLeftY);
      if ((px13 >= tl_x) && ({1'b0, px13} < ({1'b0, tl_x} + TILE14)) &&
          (py13 >= tl_y) && ({1'b0, py13} < ({1'b0, tl_y} + TILE14))) begin
        hit_p0        = 1'b1;
        idx_p0        = 3'(i);
        ox_p0         = 11'(px13 - tl_x);
        oy_p0         = 11'(py13 - tl_y);
        accent_sel_p0 = is_accent(11'(px13 - tl_x), 11'(py13 - tl_y)) ^
                        ((state[i] == COOLDOWN) && !blink_phase[i]);
      end
    end
  end

  // Stage p1: registered drawing outputs; houseIndex keeps its last value on a miss
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      houseIndex     <= '0;
      offsetX        <= '0;
      offsetY        <= '0;
      RGBout         <= 8'hFF;
    end else begin
      drawingRequest <= hit_p0;
      if (hit_p0) begin
        houseIndex <= idx_p0;
        offsetX    <= ox_p0;
        offsetY    <= oy_p0;
        RGBout     <= accent_sel_p0 ? COLOR_ACCENT : COLOR_BODY;
      end else begin
        offsetX <= '0;
        offsetY <= '0;
        RGBout  <= 8'hFF;
      end
    end
  end

endmodule
